axi4_lite_master: RTL
=====================

// Module: axi4_lite_master
// PURPOSE
//  Initiator end of the AXI4-Lite link: converts single-beat load/store requests from the
//  processor memory stage into AXI4-Lite read/write transactions toward the slave data memory.
//  One outstanding transaction at a time; busy flag stalls the pipeline until the response returns.
// PARAMETERS
//  ADDRESS     32  address width of cpu_addr / M_AWADDR / M_ARADDR
//  DATA_WIDTH  32  data width (strobe width fixed at 4 bits)
// PORTS
//  ACLK        in   1       clock, all logic on rising edge
//  ARESETN     in   1       asynchronous active-low reset
//  cpu_req     in   1       request strobe, sampled only when cpu_ready=1
//  cpu_we      in   1       1=write, 0=read
//  cpu_addr    in   ADDRESS byte address
//  cpu_wdata   in   DATA_WIDTH store data
//  cpu_wstrb   in   4       byte enables for store
//  cpu_ready   out  1       1 when idle and able to accept a request
//  cpu_done    out  1       one-cycle pulse: transaction complete
//  cpu_rdata   out  DATA_WIDTH load data, valid with cpu_done (read), held until next read done
//  cpu_err     out  1       with cpu_done: response was SLVERR/DECERR (RESP[1]=1)
//  M_AWADDR    out  ADDRESS write address
//  M_AWVALID   out  1       write address valid
//  M_AWREADY   in   1       write address ready
//  M_WDATA     out  DATA_WIDTH write data
//  M_WSTRB     out  4       write strobes
//  M_WVALID    out  1       write data valid
//  M_WREADY    in   1       write data ready
//  M_BRESP     in   2       write response
//  M_BVALID    in   1       write response valid
//  M_BREADY    out  1       write response ready
//  M_ARADDR    out  ADDRESS read address
//  M_ARVALID   out  1       read address valid
//  M_ARREADY   in   1       read address ready
//  M_RDATA     in   DATA_WIDTH read data
//  M_RRESP     in   2       read response
//  M_RVALID    in   1       read data valid
//  M_RREADY    out  1       read data ready
// BEHAVIOUR
//  Reset: all VALID/READY outputs, cpu_done, cpu_err = 0; cpu_rdata, addr/data regs = 0;
//   state=IDLE; cpu_ready=1. Reset mid-transaction aborts it immediately, no done pulse.
//  All AXI outputs are registered; cpu_ready = (state==IDLE), combinational.
//  States: IDLE, WRITE, WRESP, RADDR, RDATA.
//  IDLE: cpu_req&cpu_we -> latch addr/wdata/wstrb, AWVALID=WVALID=1, -> WRITE.
//   cpu_req&!cpu_we -> latch addr, ARVALID=1, -> RADDR. Requests outside IDLE ignored.
//  WRITE: aw_done/w_done flags track each handshake independently; AWVALID drops the cycle
//   after AWVALID&AWREADY, WVALID likewise; either order or same cycle legal.
//   Both done -> BREADY=1, -> WRESP. Address/data never change while VALID high.
//  WRESP: on BVALID&BREADY: BREADY=0, cpu_done=1 next cycle, cpu_err=BRESP[1], -> IDLE.
//  RADDR: on ARVALID&ARREADY: ARVALID=0, RREADY=1, -> RDATA.
//  RDATA: on RVALID&RREADY: capture RDATA into cpu_rdata, cpu_err=RRESP[1], cpu_done pulse,
//   RREADY=0, -> IDLE.
//  Min latency req->done: write 3 cycles (AW/W 1, B 1), read 3 cycles with zero-wait slave.
//  VALIDs never withdrawn before handshake; slave stall of any length is tolerated (no timeout).
//  cpu_done high exactly one cycle; cpu_err meaningful only with cpu_done, 0 otherwise.
//  EXOKAY (2'b01) treated as success.
// STRUCTURE
//  Shared package axi4_lite_pkg: state enum axi_mst_state_t, RESP constants OKAY/EXOKAY/SLVERR/DECERR.
//  Single flat module; no sub-module.
// TESTING
//  Write 0xDEADBEEF @0x10 strb 0xF, slave AWREADY/WREADY same cycle, BRESP=OKAY -> done at 3rd cycle, err=0.
//  Write with WREADY 2 cycles before AWREADY -> WVALID drops after its handshake, AWVALID held; one B, err=0.
//  Read @0x20, ARREADY delayed 4 cycles, RDATA=0x12345678 -> ARADDR stable, cpu_rdata=0x12345678, done 1 cycle.
//  Read returning RRESP=SLVERR -> cpu_done=1 with cpu_err=1; next write with OKAY -> cpu_err=0.
//  cpu_req pulsed while in RDATA -> ignored; exactly one AR observed on bus.
//  ARESETN low while in WRITE with AWVALID=1 -> all VALIDs 0 asynchronously, no done, cpu_ready=1 after release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi4_lite_pkg
//  Shared definitions for the AXI4-Lite initiator:
//    axi_mst_state_t  - transaction state machine encoding
//    RESP_*           - AXI response codes
//    resp_is_error()  - true for SLVERR/DECERR; EXOKAY counts as success
// ---------------------------------------------------------------------------
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4
  } axi_mst_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Both error codes have the MSB set, so one bit decides.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// ---------------------------------------------------------------------------
// axi4_lite_master
//  Turns single-beat load/store requests from the CPU memory stage into
//  AXI4-Lite transactions. Exactly one transaction is in flight at a time;
//  cpu_ready is low until the response has been returned.
//
//  Ports
//    ACLK, ARESETN             clock, asynchronous active-low reset
//    cpu_req/we/addr/wdata/wstrb  request, accepted only while cpu_ready=1
//    cpu_ready                 idle (combinational from state)
//    cpu_done                  one-cycle completion pulse
//    cpu_rdata                 load data, updated on read completion, held
//    cpu_err                   with cpu_done: response was SLVERR/DECERR
//    M_AW*, M_W*, M_B*         AXI4-Lite write channels
//    M_AR*, M_R*               AXI4-Lite read channels
//  All AXI outputs come straight from registers.
// ---------------------------------------------------------------------------
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDRESS-1:0]    cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  output logic [ADDRESS-1:0]    M_AWADDR,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [DATA_WIDTH-1:0] M_WDATA,
  output logic [3:0]            M_WSTRB,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  output logic [ADDRESS-1:0]    M_ARADDR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  axi_mst_state_t        state_reg;
  logic [ADDRESS-1:0]    addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [3:0]            wstrb_reg;
  logic                  awvalid_reg;
  logic                  wvalid_reg;
  logic                  bready_reg;
  logic                  arvalid_reg;
  logic                  rready_reg;
  logic                  aw_done_reg;
  logic                  w_done_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic aw_fire;
  logic w_fire;
  logic b_fire;
  logic ar_fire;
  logic r_fire;

  assign aw_fire = awvalid_reg & M_AWREADY;
  assign w_fire  = wvalid_reg  & M_WREADY;
  assign b_fire  = bready_reg  & M_BVALID;
  assign ar_fire = arvalid_reg & M_ARREADY;
  assign r_fire  = rready_reg  & M_RVALID;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      // Completion outputs are single-cycle pulses unless re-asserted below.
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cpu_req) begin
            addr_reg <= cpu_addr;
            if (cpu_we) begin
              wdata_reg   <= cpu_wdata;
              wstrb_reg   <= cpu_wstrb;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              aw_done_reg <= 1'b0;
              w_done_reg  <= 1'b0;
              state_reg   <= ST_WRITE;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= ST_RADDR;
            end
          end
        end
        ST_WRITE: begin
          // AW and W complete independently, in any order.
          if (aw_fire) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (w_fire) begin
            wvalid_reg <= 1'b0;
            w_done_reg <= 1'b1;
          end
          if ((aw_done_reg | aw_fire) && (w_done_reg | w_fire)) begin
            bready_reg  <= 1'b1;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            state_reg   <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (b_fire) begin
            bready_reg <= 1'b0;
            done_reg   <= 1'b1;
            err_reg    <= resp_is_error(M_BRESP);
            state_reg  <= ST_IDLE;
          end
        end
        ST_RADDR: begin
          if (ar_fire) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (r_fire) begin
            rready_reg <= 1'b0;
            rdata_reg  <= M_RDATA;
            done_reg   <= 1'b1;
            err_reg    <= resp_is_error(M_RRESP);
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cpu_ready = (state_reg == ST_IDLE);
  assign cpu_done  = done_reg;
  assign cpu_err   = err_reg;
  assign cpu_rdata = rdata_reg;

  // One latched address serves both channels; only one is ever valid.
  assign M_AWADDR  = addr_reg;
  assign M_ARADDR  = addr_reg;
  assign M_AWVALID = awvalid_reg;
  assign M_WDATA   = wdata_reg;
  assign M_WSTRB   = wstrb_reg;
  assign M_WVALID  = wvalid_reg;
  assign M_BREADY  = bready_reg;
  assign M_ARVALID = arvalid_reg;
  assign M_RREADY  = rready_reg;

endmodule
